// File: rtl/ip_codma_machine_states_pkg.sv
// rtl/ip_codma_machine_states_pkg.sv - responder states, burst size codes and beat decode
package ip_codma_machine_states_pkg;

  typedef enum logic [2:0] {
    RESP_IDLE,
    RESP_GRANT,
    RESP_READ,
    RESP_WRITE,
    RESP_ERROR
  } resp_state_t;

  localparam logic [3:0] SIZE_1BEAT = 4'd3;
  localparam logic [3:0] SIZE_3BEAT = 4'd8;
  localparam logic [3:0] SIZE_4BEAT = 4'd9;

  // Zero beats marks an illegal size code.
  function automatic logic [2:0] beats_for_size(input logic [3:0] size);
    case (size)
      SIZE_1BEAT: return 3'd1;
      SIZE_3BEAT: return 3'd3;
      SIZE_4BEAT: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ip_codma_resp_mem.sv
// rtl/ip_codma_resp_mem.sv - single-port 64-bit RAM, synchronous write, registered read
module ip_codma_resp_mem #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem_q [MEM_WORDS];

  // The array itself is never reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  rdata <= '0;
    else if (re)     rdata <= mem_q[addr];
  end

endmodule

// File: rtl/ip_codma_bus_responder.sv
// rtl/ip_codma_bus_responder.sv - codma bus target serving bursts from an internal RAM
// Define IP_CODMA_RESP_WAIT_EN for LFSR-driven grant stalls and read gaps.
module ip_codma_bus_responder
  import ip_codma_machine_states_pkg::*;
#(
  parameter int         MEM_WORDS = 256,
  parameter int         AW        = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  size_i,
  input  logic [63:0] write_data_i,
  input  logic        write_valid_i,
  output logic        grant_o,
  output logic        read_valid_o,
  output logic [63:0] read_data_o,
  output logic        error_o,
  output logic        busy_o
);

  if ((1 << AW) != MEM_WORDS || LFSR_SEED == 8'h00) begin : g_bad_cfg
    $error("ip_codma_bus_responder: inconsistent MEM_WORDS/AW or zero LFSR_SEED");
  end

  resp_state_t   state_q, state_d;
  logic          write_q;
  logic [AW-1:0] idx_q;
  logic [2:0]    beats_q;
  logic [2:0]    beat_q, beat_d;
  logic          rvalid_q, rvalid_d;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [2:0]    req_beats;
  logic [32:0]   req_end;
  logic          req_legal;
  logic          stall;
  logic          gap_next;

  assign req_beats = beats_for_size(size_i);
  assign req_end   = {4'd0, addr_i[31:3]} + {30'd0, req_beats};
  assign req_legal = (req_beats != 3'd0) && (addr_i[2:0] == 3'd0) &&
                     (req_end <= 33'(MEM_WORDS));

`ifdef IP_CODMA_RESP_WAIT_EN
  logic [7:0] lfsr_q, lfsr_next;
  logic [2:0] wait_q;

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_q <= LFSR_SEED;
      wait_q <= 3'd0;
    end else begin
      lfsr_q <= lfsr_next;
      if (state_q == RESP_IDLE && req_i && req_legal) wait_q <= lfsr_q[2:0];
      else if (state_q == RESP_GRANT && wait_q != 3'd0) wait_q <= wait_q - 3'd1;
    end
  end

  assign stall    = (wait_q != 3'd0);
  // A beat issued now shows next cycle, so the gap decision uses next cycle's LFSR.
  assign gap_next = lfsr_next[0];
`else
  assign stall    = 1'b0;
  assign gap_next = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= RESP_IDLE;
      beat_q   <= 3'd0;
      rvalid_q <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      beats_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      if (state_q == RESP_IDLE && req_i) begin
        write_q <= write_i;
        idx_q   <= addr_i[AW+2:3];
        beats_q <= req_beats;
      end
    end
  end

  // In RESP_READ beat_q counts beats issued to the RAM, one cycle ahead of read_valid_o.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rvalid_d = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = idx_q + AW'(beat_q);
    unique case (state_q)
      RESP_IDLE: begin
        beat_d = 3'd0;
        if (req_i) state_d = req_legal ? RESP_GRANT : RESP_ERROR;
      end
      RESP_GRANT: begin
        if (!stall) begin
          if (write_q) begin
            state_d = RESP_WRITE;
          end else begin
            state_d = RESP_READ;
            if (!gap_next) begin
              mem_re   = 1'b1;
              rvalid_d = 1'b1;
              beat_d   = 3'd1;
            end
          end
        end
      end
      RESP_READ: begin
        if (rvalid_q && beat_q == beats_q) begin
          state_d = RESP_IDLE;
        end else if (beat_q != beats_q && !gap_next) begin
          mem_re   = 1'b1;
          rvalid_d = 1'b1;
          beat_d   = beat_q + 3'd1;
        end
      end
      RESP_WRITE: begin
        if (write_valid_i) begin
          mem_we = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_d == beats_q) state_d = RESP_IDLE;
        end
      end
      RESP_ERROR: state_d = RESP_IDLE;
      default:    state_d = RESP_IDLE;
    endcase
  end

  ip_codma_resp_mem #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_mem (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .we        (mem_we),
    .re        (mem_re),
    .addr      (mem_addr),
    .wdata     (write_data_i),
    .rdata     (read_data_o)
  );

  assign grant_o      = (state_q == RESP_GRANT) && !stall;
  assign read_valid_o = rvalid_q;
  assign error_o      = (state_q == RESP_ERROR);
  assign busy_o       = (state_q != RESP_IDLE) || req_i;

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// tb/tb_ip_codma_bus_responder.sv - directed scoreboard bench for ip_codma_bus_responder
module tb_ip_codma_bus_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        req_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  size_i = '0;
  logic [63:0] write_data_i = '0;
  logic        write_valid_i = 1'b0;
  logic        grant_o, read_valid_o, error_o, busy_o;
  logic [63:0] read_data_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] mem_m [256];
  logic [63:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  ip_codma_bus_responder dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .req_i         (req_i),
    .write_i       (write_i),
    .addr_i        (addr_i),
    .size_i        (size_i),
    .write_data_i  (write_data_i),
    .write_valid_i (write_valid_i),
    .grant_o       (grant_o),
    .read_valid_o  (read_valid_o),
    .read_data_o   (read_data_o),
    .error_o       (error_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_n_i && read_valid_o) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL rd_extra observed=%h expected=no_beat", read_data_o);
      end
      if (exp_q.size() > 0) check("rd_data", read_data_o, exp_q.pop_front());
    end
  end

  task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [3:0] size);
    @(negedge clk_i);
    req_i = 1'b1;
    write_i = wr;
    addr_i = addr;
    size_i = size;
  endtask

  task automatic wait_grant(input string tag);
    int cnt = 0;
    do begin
      @(negedge clk_i);
      cnt++;
    end while (!grant_o && cnt < 40);
    check({tag, "_grant"}, 64'(grant_o), 64'd1);
`ifndef IP_CODMA_RESP_WAIT_EN
    check({tag, "_grant_lat"}, 64'(cnt), 64'd1);
`endif
    req_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] size,
                          input int nbeats, input logic [63:0] base);
    issue_req(1'b1, addr, size);
    wait_grant("wr");
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk_i);
      write_valid_i = 1'b1;
      write_data_i = base + 64'(k);
      mem_m[addr[10:3] + 8'(k)] = base + 64'(k);
    end
    @(negedge clk_i);
    write_valid_i = 1'b0;
    check("wr_done_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] size, input int nbeats);
    int cnt = 0;
    for (int k = 0; k < nbeats; k++) exp_q.push_back(mem_m[addr[10:3] + 8'(k)]);
    issue_req(1'b0, addr, size);
    wait_grant("rd");
`ifndef IP_CODMA_RESP_WAIT_EN
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk_i);
      check("rd_valid_run", 64'(read_valid_o), 64'd1);
    end
    @(negedge clk_i);
`else
    do begin
      @(negedge clk_i);
      cnt++;
    end while ((exp_q.size() != 0 || busy_o) && cnt < 80);
`endif
    check("rd_end_valid", 64'(read_valid_o), 64'd0);
    check("rd_end_busy", 64'(busy_o), 64'd0);
    check("rd_queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_err(input logic [31:0] addr, input logic [3:0] size);
    issue_req(1'b0, addr, size);
    #1 check("err_busy_c0", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    req_i = 1'b0;
    check("err_pulse", 64'(error_o), 64'd1);
    check("err_busy_c1", 64'(busy_o), 64'd1);
    check("err_no_grant", 64'(grant_o), 64'd0);
    @(negedge clk_i);
    check("err_pulse_end", 64'(error_o), 64'd0);
    check("err_busy_end", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int nv;
    #1;
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_rvalid", 64'(read_valid_o), 64'd0);
    check("rst_rdata", read_data_o, 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;

    do_write(32'h40, 4'd9, 4, 64'd1);
    do_read(32'h40, 4'd9, 4);

    do_write(32'h08, 4'd8, 3, 64'h100);
    issue_req(1'b1, 32'h08, 4'd3);
    wait_grant("gap");
    @(negedge clk_i);
    write_valid_i = 1'b1;
    write_data_i = 64'hA5A5_0000_0000_00AA;
    mem_m[1] = 64'hA5A5_0000_0000_00AA;
    @(negedge clk_i);
    write_valid_i = 1'b0;
    check("gap_wr_idle_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    write_valid_i = 1'b1;
    write_data_i = 64'hBBBB_0000_0000_00BB;
    @(negedge clk_i);
    write_valid_i = 1'b0;
    do_read(32'h08, 4'd8, 3);

    do_write(32'h7E8, 4'd8, 3, 64'h1111_0000_0000_0000);
    do_read(32'h7E8, 4'd8, 3);
    do_err(32'h7E8, 4'd9);
    do_err(32'h40, 4'd5);
    do_err(32'h44, 4'd3);
    do_read(32'h40, 4'd9, 4);

    for (int k = 0; k < 4; k++) exp_q.push_back(mem_m[8 + k]);
    issue_req(1'b0, 32'h40, 4'd9);
    wait_grant("rst");
    nv = 0;
    for (int i = 0; i < 60 && nv < 2; i++) begin
      @(negedge clk_i);
      if (read_valid_o) nv++;
    end
    check("rst_mid_beats_seen", 64'(nv), 64'd2);
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(read_valid_o), 64'd0);
    check("rst_mid_rdata", read_data_o, 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_grant", 64'(grant_o), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    do_read(32'h40, 4'd9, 4);
    do_read(32'h08, 4'd8, 3);

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
